// File: rtl/cache_req_arbiter.sv
// Purpose: round-robin arbiter between the AXI AR channel and the AW+W channel pair; packs each grant
//   into a 128-bit request word, with write bursts expanded to one packed request per W beat.
// Latency: 1 cycle from an AR or W handshake to req_valid. Backpressure: a held output
//   (req_valid && !req_ready) drops ar_ready and w_ready. aw_ready does not depend on the output stage.
// Ports: clk/rst (async active-high); ar_*, aw_*, w_* AXI request channels with valid/ready;
//   req_valid/req_ready + read_or_write + result_arb output stage; err_wlast length-mismatch pulse.
module cache_req_arbiter #(
  parameter bit INIT_PRIO = 1'b0,
  parameter bit CHECK_LEN = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ar_valid,
  output logic         ar_ready,
  input  logic [31:0]  ar_addr,
  input  logic [3:0]   ar_id,
  input  logic [1:0]   ar_burst,
  input  logic [2:0]   ar_size,
  input  logic [7:0]   ar_len,
  input  logic         aw_valid,
  output logic         aw_ready,
  input  logic [31:0]  aw_addr,
  input  logic [3:0]   aw_id,
  input  logic [1:0]   aw_burst,
  input  logic [2:0]   aw_size,
  input  logic [7:0]   aw_len,
  input  logic         w_valid,
  output logic         w_ready,
  input  logic [63:0]  w_data,
  input  logic [7:0]   w_strb,
  input  logic         w_last,
  output logic         req_valid,
  input  logic         req_ready,
  output logic         read_or_write,
  output logic [127:0] result_arb,
  output logic         err_wlast
);

  typedef enum logic {IDLE, WR_BURST} state_t;

  state_t      state;
  logic        last_grant;   // 0 = read was granted last, 1 = write
  logic [3:0]  h_id;
  logic [1:0]  h_burst;
  logic [2:0]  h_size;
  logic [7:0]  h_len;
  logic [7:0]  beat_cnt;
  logic [31:0] cur_addr;

  logic        load_ok;
  logic        grant_rd;
  logic        grant_wr;
  logic        ar_hs;
  logic        aw_hs;
  logic        w_hs;
  logic [31:0] incr;
  logic [31:0] wrap_mask;
  logic [31:0] next_addr;

  assign load_ok = !req_valid || req_ready;

  // On contention the side that did not win last time gets the grant.
  always_comb begin
    grant_rd = 1'b0;
    grant_wr = 1'b0;
    if (!rst && state == IDLE) begin
      if (ar_valid && aw_valid) begin
        grant_wr = (last_grant == 1'b0);
        grant_rd = (last_grant == 1'b1);
      end else begin
        grant_rd = ar_valid;
        grant_wr = aw_valid;
      end
    end
  end

  assign ar_ready = grant_rd && load_ok;
  assign aw_ready = grant_wr;
  assign w_ready  = !rst && (state == WR_BURST) && load_ok;

  assign ar_hs = ar_valid && ar_ready;
  assign aw_hs = aw_valid && aw_ready;
  assign w_hs  = w_valid && w_ready;

  // WRAP keeps the low address bits inside a window of (len+1)<<size bytes. The mask form
  // relies on len+1 being a power of two, which holds for every legal AXI wrapping burst.
  always_comb begin
    incr      = 32'd1 << h_size;
    wrap_mask = ((32'(h_len) + 32'd1) << h_size) - 32'd1;
    case (h_burst)
      2'b00:   next_addr = cur_addr;
      2'b10:   next_addr = (cur_addr & ~wrap_mask) | ((cur_addr + incr) & wrap_mask);
      default: next_addr = cur_addr + incr;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      last_grant    <= ~INIT_PRIO;
      h_id          <= '0;
      h_burst       <= '0;
      h_size        <= '0;
      h_len         <= '0;
      beat_cnt      <= '0;
      cur_addr      <= '0;
      req_valid     <= 1'b0;
      read_or_write <= 1'b0;
      result_arb    <= '0;
      err_wlast     <= 1'b0;
    end else begin
      err_wlast <= 1'b0;

      // Output stage: a new load wins over the drain of the current word.
      if (ar_hs) begin
        result_arb    <= {79'd0, ar_addr, ar_id, ar_burst, ar_size, ar_len};
        read_or_write <= 1'b0;
        req_valid     <= 1'b1;
      end else if (w_hs) begin
        result_arb    <= {7'd0, cur_addr, h_id, h_burst, h_size, h_len, w_data, w_strb};
        read_or_write <= 1'b1;
        req_valid     <= 1'b1;
      end else if (req_ready) begin
        req_valid <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (ar_hs) begin
            last_grant <= 1'b0;
          end else if (aw_hs) begin
            h_id       <= aw_id;
            h_burst    <= aw_burst;
            h_size     <= aw_size;
            h_len      <= aw_len;
            beat_cnt   <= 8'd0;
            cur_addr   <= aw_addr;
            last_grant <= 1'b1;
            state      <= WR_BURST;
          end
        end
        WR_BURST: begin
          if (w_hs) begin
            if (beat_cnt != 8'hff) beat_cnt <= beat_cnt + 8'd1;
            cur_addr  <= next_addr;
            // Flags the mismatch only; the burst still ends on w_last alone.
            err_wlast <= CHECK_LEN && ((w_last && beat_cnt != h_len) || (!w_last && beat_cnt == h_len));
            if (w_last) state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cache_req_arbiter.sv
module tb_cache_req_arbiter;
  logic         clk;
  logic         rst;
  logic         ar_valid, ar_ready;
  logic [31:0]  ar_addr;
  logic [3:0]   ar_id;
  logic [1:0]   ar_burst;
  logic [2:0]   ar_size;
  logic [7:0]   ar_len;
  logic         aw_valid, aw_ready;
  logic [31:0]  aw_addr;
  logic [3:0]   aw_id;
  logic [1:0]   aw_burst;
  logic [2:0]   aw_size;
  logic [7:0]   aw_len;
  logic         w_valid, w_ready;
  logic [63:0]  w_data;
  logic [7:0]   w_strb;
  logic         w_last;
  logic         req_valid, req_ready, read_or_write, err_wlast;
  logic [127:0] result_arb;

  int checks = 0;
  int errors = 0;
  int bp_mode = 0;            // 0: req_ready=1, 1: random, 2: req_ready=0
  logic [128:0] got_q[$];
  logic [128:0] exp_q[$];

  cache_req_arbiter #(.INIT_PRIO(1'b0), .CHECK_LEN(1'b1)) dut (
    .clk(clk), .rst(rst),
    .ar_valid(ar_valid), .ar_ready(ar_ready), .ar_addr(ar_addr), .ar_id(ar_id),
    .ar_burst(ar_burst), .ar_size(ar_size), .ar_len(ar_len),
    .aw_valid(aw_valid), .aw_ready(aw_ready), .aw_addr(aw_addr), .aw_id(aw_id),
    .aw_burst(aw_burst), .aw_size(aw_size), .aw_len(aw_len),
    .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data), .w_strb(w_strb), .w_last(w_last),
    .req_valid(req_valid), .req_ready(req_ready), .read_or_write(read_or_write),
    .result_arb(result_arb), .err_wlast(err_wlast)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Record every accepted output word as {read_or_write, result_arb}.
  always @(posedge clk) begin
    if (!rst && req_valid && req_ready) got_q.push_back({read_or_write, result_arb});
  end

  always @(negedge clk) begin
    if (!rst) begin
      checks++;
      assert (!(ar_ready && aw_ready)) else begin
        errors++;
        $error("FAIL ready_excl ar_ready=%0b aw_ready=%0b required not both 1", ar_ready, aw_ready);
      end
    end
  end

  task automatic chk(input string tag, input logic [128:0] obs, input logic [128:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] rd_pkt(logic [31:0] a, logic [3:0] id, logic [1:0] b,
                                          logic [2:0] s, logic [7:0] l);
    return {79'd0, a, id, b, s, l};
  endfunction

  function automatic logic [127:0] wr_pkt(logic [31:0] a, logic [3:0] id, logic [1:0] b,
                                          logic [2:0] s, logic [7:0] l, logic [63:0] d, logic [7:0] st);
    return {7'd0, a, id, b, s, l, d, st};
  endfunction

  // Address of the following beat, from the burst rules in plain arithmetic.
  function automatic logic [31:0] model_next(logic [31:0] a, logic [1:0] b, logic [2:0] s, logic [7:0] l);
    longint unsigned stp, win, base, nxt;
    stp = 64'd1 << s;
    if (b == 2'b00) return a;
    if (b == 2'b10) begin
      win  = (longint'(l) + 1) * stp;
      base = a - (a % win);
      nxt  = a + stp;
      if (nxt >= base + win) nxt = nxt - win;
      return nxt[31:0];
    end
    nxt = a + stp;
    return nxt[31:0];
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
    case (bp_mode)
      0:       req_ready = 1'b1;
      1:       req_ready = ($urandom_range(0, 3) != 0);
      default: req_ready = 1'b0;
    endcase
  endtask

  // which: 0=ar_ready 1=aw_ready 2=w_ready. Returns at the negedge before the handshaking edge.
  task automatic wait_hs(input int which, input string tag);
    bit ok = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if ((which == 0 && ar_ready) || (which == 1 && aw_ready) || (which == 2 && w_ready)) begin
        ok = 1;
        break;
      end
      step();
    end
    if (!ok) chk({tag, "_timeout"}, 129'd0, 129'd1);
  endtask

  task automatic do_read(input logic [31:0] a, input logic [3:0] id, input logic [1:0] b,
                         input logic [2:0] s, input logic [7:0] l);
    ar_addr = a; ar_id = id; ar_burst = b; ar_size = s; ar_len = l;
    ar_valid = 1'b1;
    wait_hs(0, "ar");
    step();
    ar_valid = 1'b0;
    exp_q.push_back({1'b0, rd_pkt(a, id, b, s, l)});
  endtask

  task automatic do_write(input logic [31:0] a, input logic [3:0] id, input logic [1:0] b,
                          input logic [2:0] s, input logic [7:0] l, input int nbeats);
    logic [31:0] addr;
    int bc;
    bit exp_err;
    aw_addr = a; aw_id = id; aw_burst = b; aw_size = s; aw_len = l;
    aw_valid = 1'b1;
    wait_hs(1, "aw");
    step();
    aw_valid = 1'b0;
    addr = a;
    for (int k = 0; k < nbeats; k++) begin
      w_data  = {$urandom, $urandom};
      w_strb  = 8'($urandom);
      w_last  = (k == nbeats - 1);
      w_valid = 1'b1;
      wait_hs(2, "w");
      step();
      w_valid = 1'b0;
      bc = (k > 255) ? 255 : k;
      exp_err = (w_last && bc != int'(l)) || (!w_last && bc == int'(l));
      chk("err_wlast", {128'd0, err_wlast}, {128'd0, exp_err});
      exp_q.push_back({1'b1, wr_pkt(addr, id, b, s, l, w_data, w_strb)});
      addr = model_next(addr, b, s, l);
    end
    w_last = 1'b0;
  endtask

  task automatic drain();
    int n;
    bp_mode = 0;
    req_ready = 1'b1;
    for (int i = 0; i < 300 && got_q.size() < exp_q.size(); i++) step();
    step();
    step();
    chk("pkt_count", 129'(got_q.size()), 129'(exp_q.size()));
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) chk($sformatf("pkt%0d", i), got_q[i], exp_q[i]);
    got_q.delete();
    exp_q.delete();
  endtask

  initial begin
    logic [127:0] pkt0, pkt1;
    logic [7:0]   lens[4];
    int           g[4];
    int           ng;
    int           nb;
    logic [7:0]   ln;

    rst = 1'b1; req_ready = 1'b1;
    ar_valid = 1'b1; ar_addr = '0; ar_id = '0; ar_burst = '0; ar_size = '0; ar_len = '0;
    aw_valid = 1'b1; aw_addr = '0; aw_id = '0; aw_burst = '0; aw_size = '0; aw_len = '0;
    w_valid = 1'b1; w_data = '0; w_strb = '0; w_last = 1'b0;
    lens[0] = 8'd0; lens[1] = 8'd1; lens[2] = 8'd3; lens[3] = 8'd7;

    // Reset state, with every valid asserted.
    repeat (2) @(negedge clk);
    chk("rst_req_valid", {128'd0, req_valid}, 129'd0);
    chk("rst_rw", {128'd0, read_or_write}, 129'd0);
    chk("rst_result", {1'b0, result_arb}, 129'd0);
    chk("rst_err", {128'd0, err_wlast}, 129'd0);
    chk("rst_readies", {126'd0, ar_ready, aw_ready, w_ready}, 129'd0);
    ar_valid = 1'b0; aw_valid = 1'b0; w_valid = 1'b0;
    @(posedge clk); #1 rst = 1'b0;
    step();

    // Single read: one-cycle latency, exact packing.
    do_read(32'h0000_1238, 4'd3, 2'd1, 3'd3, 8'd0);
    chk("rd_valid", {128'd0, req_valid}, 129'd1);
    chk("rd_rw", {128'd0, read_or_write}, 129'd0);
    chk("rd_result", {1'b0, result_arb}, {1'b0, rd_pkt(32'h1238, 4'd3, 2'd1, 3'd3, 8'd0)});
    drain();

    // Contention from a fresh reset: R,W,R,W.
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    ar_addr = 32'h40; ar_id = 4'd1; ar_burst = 2'd1; ar_size = 3'd2; ar_len = 8'd0;
    aw_addr = 32'h80; aw_id = 4'd2; aw_burst = 2'd1; aw_size = 3'd2; aw_len = 8'd0;
    ar_valid = 1'b1; aw_valid = 1'b1; w_valid = 1'b1; w_last = 1'b1;
    for (int i = 0; i < 4; i++) g[i] = 9;
    ng = 0;
    for (int c = 0; c < 60 && ng < 4; c++) begin
      @(negedge clk);
      if (ar_ready) begin g[ng] = 0; ng++; end
      else if (aw_ready) begin g[ng] = 1; ng++; end
      step();
    end
    ar_valid = 1'b0; aw_valid = 1'b0;
    step();
    step();
    w_valid = 1'b0; w_last = 1'b0;
    for (int i = 0; i < 4; i++) chk($sformatf("grant%0d", i), 129'(g[i]), 129'(i % 2));
    repeat (3) step();
    got_q.delete();
    exp_q.delete();

    // INCR then WRAP bursts; afterwards W is not accepted in IDLE.
    do_write(32'h100, 4'd5, 2'd1, 3'd3, 8'd3, 4);
    do_write(32'h118, 4'd6, 2'd2, 3'd3, 8'd3, 4);
    w_valid = 1'b1;
    @(negedge clk);
    chk("idle_no_wready", {128'd0, w_ready}, 129'd0);
    step();
    w_valid = 1'b0;
    drain();

    // Backpressure: held word, no ready on W/AR, then no bubble when released.
    bp_mode = 2; req_ready = 1'b0;
    aw_addr = 32'h200; aw_id = 4'd2; aw_burst = 2'd1; aw_size = 3'd2; aw_len = 8'd1;
    aw_valid = 1'b1;
    wait_hs(1, "bp_aw");
    step();
    aw_valid = 1'b0;
    w_data = 64'h1111_2222_3333_4444; w_strb = 8'h0f; w_last = 1'b0; w_valid = 1'b1;
    wait_hs(2, "bp_w0");
    step();
    pkt0 = wr_pkt(32'h200, 4'd2, 2'd1, 3'd2, 8'd1, 64'h1111_2222_3333_4444, 8'h0f);
    w_data = 64'h5555_6666_7777_8888; w_strb = 8'hf0; w_last = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_w_ready", {128'd0, w_ready}, 129'd0);
      chk("bp_hold_valid", {128'd0, req_valid}, 129'd1);
      chk("bp_hold_result", {1'b0, result_arb}, {1'b0, pkt0});
      step();
    end
    bp_mode = 0; req_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_w_ready", {128'd0, w_ready}, 129'd1);
    step();
    w_valid = 1'b0; w_last = 1'b0;
    pkt1 = wr_pkt(32'h204, 4'd2, 2'd1, 3'd2, 8'd1, 64'h5555_6666_7777_8888, 8'hf0);
    chk("bp_nobubble_valid", {128'd0, req_valid}, 129'd1);
    chk("bp_nobubble_result", {1'b0, result_arb}, {1'b0, pkt1});
    exp_q.push_back({1'b1, pkt0});
    exp_q.push_back({1'b1, pkt1});
    bp_mode = 2; req_ready = 1'b0;
    ar_addr = 32'h300; ar_id = 4'd9; ar_burst = 2'd0; ar_size = 3'd1; ar_len = 8'd5;
    ar_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_ar_ready", {128'd0, ar_ready}, 129'd0);
      chk("bp_hold_pkt1", {1'b0, result_arb}, {1'b0, pkt1});
      step();
    end
    bp_mode = 0; req_ready = 1'b1;
    wait_hs(0, "bp_ar");
    step();
    ar_valid = 1'b0;
    exp_q.push_back({1'b0, rd_pkt(32'h300, 4'd9, 2'd0, 3'd1, 8'd5)});
    drain();

    // Length mismatches: early w_last, then a late one; each burst still ends on w_last.
    do_write(32'h300, 4'd7, 2'd1, 3'd3, 8'd3, 2);
    do_write(32'h400, 4'd1, 2'd1, 3'd2, 8'd1, 3);
    drain();

    // Randomized mix under random backpressure.
    bp_mode = 1;
    for (int t = 0; t < 40; t++) begin
      if ($urandom_range(0, 1) == 0) begin
        do_read($urandom, 4'($urandom), 2'($urandom), 3'($urandom), 8'($urandom));
      end else begin
        ln = lens[$urandom_range(0, 3)];
        nb = int'(ln) + 1;
        if ($urandom_range(0, 5) == 0) nb = (ln == 0 || $urandom_range(0, 1) == 0) ? nb + 1 : nb - 1;
        do_write($urandom, 4'($urandom), 2'($urandom), 3'($urandom_range(0, 3)), ln, nb);
      end
    end
    drain();

    // Reset in the middle of a burst with a held output word.
    bp_mode = 2; req_ready = 1'b0;
    aw_addr = 32'h800; aw_id = 4'd4; aw_burst = 2'd1; aw_size = 3'd3; aw_len = 8'd3;
    aw_valid = 1'b1;
    wait_hs(1, "mr_aw");
    step();
    aw_valid = 1'b0;
    w_data = 64'hdead_beef_0000_0001; w_strb = 8'hff; w_last = 1'b0; w_valid = 1'b1;
    wait_hs(2, "mr_w");
    step();
    ar_valid = 1'b1;
    rst = 1'b1;
    #2;
    chk("mr_req_valid", {128'd0, req_valid}, 129'd0);
    chk("mr_rw", {128'd0, read_or_write}, 129'd0);
    chk("mr_result", {1'b0, result_arb}, 129'd0);
    chk("mr_err", {128'd0, err_wlast}, 129'd0);
    chk("mr_readies", {126'd0, ar_ready, aw_ready, w_ready}, 129'd0);
    ar_valid = 1'b0;
    @(posedge clk); #1 rst = 1'b0;
    bp_mode = 0; req_ready = 1'b1;
    @(negedge clk);
    chk("mr_burst_dropped", {128'd0, w_ready}, 129'd0);
    chk("mr_no_output", {128'd0, req_valid}, 129'd0);
    step();
    w_valid = 1'b0;
    repeat (2) step();
    chk("mr_no_replay", 129'(got_q.size()), 129'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
